decode_stage: RTL and testbench
===============================

Name: decode_stage

Overview:
- ID stage of the 5-stage RV32I pipeline. Consumes the IF/ID register (instruction, NPC) driven by the fetch stage.
- Reads the 32x32 register file, decodes the instruction and produces the ID/EX register.
- Detects load-use hazards and drives `hazard` back to fetch, which holds PC while asserted.
- Inserts a bubble on a taken branch (EX/MEM.cond) and on every stall cycle.

Parameters:
XLEN, 32, datapath/register width
NREGS, 32, architectural registers (x0 hardwired zero)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
if_inst  in  32  IF/ID.IR
if_npc  in  32  IF/ID.NPC
branch_cond  in  1  EX/MEM.cond; flush ID
wb_en  in  1  writeback enable
wb_rd  in  5  writeback destination
wb_data  in  32  writeback value
hazard  out  1  load-use stall request to fetch (combinational)
id_ex_valid  out  1  ID/EX holds a real instruction
id_ex_npc  out  32  ID/EX.NPC
id_ex_a  out  32  rs1 value
id_ex_b  out  32  rs2 value
id_ex_imm  out  32  sign-extended immediate
id_ex_rd  out  5  destination register
id_ex_opcode  out  7  inst[6:0]
id_ex_funct3  out  3  inst[14:12]
id_ex_funct7b5  out  1  inst[30]
id_ex_is_load  out  1  opcode LOAD
id_ex_reg_write  out  1  writes rd
illegal  out  1  current ID instruction has unsupported opcode (combinational)

Behaviour:
- Reset: all `id_ex_*` outputs 0; all 32 registers cleared to 0. `hazard` and `illegal` are combinational and not registered.
- Latency: ID/EX outputs update on the clk edge after `if_inst` is presented (1 cycle).

Supported opcodes, immediate format, source use and rd write:
- LUI 0110111: U; no sources; writes rd.
- AUIPC 0010111: U; no sources; writes rd.
- JAL 1101111: J; no sources; writes rd.
- JALR 1100111: I; uses rs1; writes rd.
- BRANCH 1100011: B; uses rs1, rs2; no rd.
- LOAD 0000011: I; uses rs1; writes rd.
- STORE 0100011: S; uses rs1, rs2; no rd.
- OP-IMM 0010011: I; uses rs1; writes rd.
- OP 0110011: imm=0; uses rs1, rs2; writes rd.

Decode rules:
- All immediates are sign-extended from inst[31]. B and J immediates have LSB 0.
- Any other opcode sets `illegal=1`; the instruction enters ID/EX as a bubble.
- `id_ex_reg_write = writes_rd && rd!=0`.
- Unused source fields still read the register file, but do not participate in hazard detection.

Register file:
- Write is synchronous: on posedge, if `wb_en && wb_rd!=0`, then `reg[wb_rd] <= wb_data`.
- x0 always reads 0, and writes to x0 are ignored.

Hazard:
- `hazard = id_ex_valid && id_ex_is_load && id_ex_reg_write && ((uses_rs1 && rs1==id_ex_rd) || (uses_rs2 && rs2==id_ex_rd)) && !branch_cond`.
- Stall length is exactly 1 cycle: the bubble clears `id_ex_is_load`, so `hazard` drops the next cycle with the same instruction still in IF/ID.

ID/EX update, in priority order each posedge:
1. reset.
2. `branch_cond`: bubble.
3. `hazard`: bubble.
4. `illegal`: bubble.
5. Otherwise load the decoded instruction with `id_ex_valid=1`.
- Bubble means `valid`, `reg_write`, `is_load`, `rd`, `opcode`, `imm`, `a`, `b`, `npc` all 0.

Simultaneous events:
- `branch_cond` with a hazard: flush wins and `hazard` is 0.
- A writeback to rs1/rs2 in the same cycle as decode is governed by the optional feature.
- Reset mid-stall clears ID/EX and drops `hazard` on the next cycle.

Optional Feature:
- Macro: DECODE_STAGE_WB_BYPASS_EN.
- Defined: write-through bypass. If `wb_en && wb_rd!=0 && wb_rd==rs`, then `id_ex_a`/`id_ex_b` capture `wb_data` in the same cycle.
- Undefined: the read returns the pre-write register contents. The hazard logic is unchanged, and the bench expects the old value.

Test Plan:
- Reset, then `if_inst=0x00500093` (addi x1,x0,5), `if_npc=4` -> next cycle `id_ex_valid=1`, `rd=1`, `imm=5`, `a=0`, `reg_write=1`, `npc=4`, `hazard=0`.
- Write x2=0x1234 via writeback, then decode `add x3,x2,x2` (0x002101B3) -> `id_ex_a=id_ex_b=0x1234`, `imm=0`; x0 write of 0xFFFF leaves x0 read at 0.
- ID/EX holds `lw x5,0(x1)`, ID has `add x6,x5,x0` -> `hazard=1` for 1 cycle and ID/EX bubble; next cycle `hazard=0` and add issues with `rd=6`.
- Load into x5 followed by `lui x5,0x12345` (no sources) -> `hazard=0`, `imm=0x12345000`.
- `branch_cond=1` while ID holds a hazarding instruction -> `hazard=0`, ID/EX bubble (`valid=0`, `reg_write=0`).
- `beq` with imm -8 (0xFE000CE3 form) -> `imm=0xFFFFFFF8`, `reg_write=0`. Opcode 0x7F -> `illegal=1` and bubble.
- Same-cycle `wb_en` x4=7 with decode of `addi x8,x4,0`:
  - macro defined -> `a=7`.
  - macro undefined -> `a=` prior x4 value.

Source files
------------

// File: rtl/decode_stage.sv
// decode_stage: ID stage of the 5-stage RV32I pipeline.
// Reads the 32-entry register file, decodes the IF/ID instruction and
// produces the ID/EX register. It raises a one-cycle load-use stall
// request to fetch and turns taken branches, stalls and illegal opcodes
// into bubbles.
// Optional feature: define DECODE_STAGE_WB_BYPASS_EN to forward a
// same-cycle writeback into the rs1/rs2 read values (write-through).
// Without it, a read in the writeback cycle returns the old contents.
module decode_stage #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [31:0]     if_inst,
    input  logic [XLEN-1:0] if_npc,
    input  logic            branch_cond,
    input  logic            wb_en,
    input  logic [4:0]      wb_rd,
    input  logic [XLEN-1:0] wb_data,
    output logic            hazard,
    output logic            id_ex_valid,
    output logic [XLEN-1:0] id_ex_npc,
    output logic [XLEN-1:0] id_ex_a,
    output logic [XLEN-1:0] id_ex_b,
    output logic [XLEN-1:0] id_ex_imm,
    output logic [4:0]      id_ex_rd,
    output logic [6:0]      id_ex_opcode,
    output logic [2:0]      id_ex_funct3,
    output logic            id_ex_funct7b5,
    output logic            id_ex_is_load,
    output logic            id_ex_reg_write,
    output logic            illegal
);

    // RV32I base opcodes handled by this stage
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_OPIMM  = 7'b0010011;
    localparam logic [6:0] OP_OP     = 7'b0110011;

    // Immediate formats; each returns the 32-bit sign-extended value.
    function automatic logic [31:0] imm_i(input logic [31:0] inst);
        return {{20{inst[31]}}, inst[31:20]};
    endfunction

    function automatic logic [31:0] imm_s(input logic [31:0] inst);
        return {{20{inst[31]}}, inst[31:25], inst[11:7]};
    endfunction

    function automatic logic [31:0] imm_b(input logic [31:0] inst);
        return {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
    endfunction

    function automatic logic [31:0] imm_u(input logic [31:0] inst);
        return {inst[31:12], 12'b0};
    endfunction

    function automatic logic [31:0] imm_j(input logic [31:0] inst);
        return {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
    endfunction

    // Widen a 32-bit immediate to the datapath width, keeping its sign.
    function automatic logic [XLEN-1:0] sext_xlen(input logic [31:0] v);
        return XLEN'($signed(v));
    endfunction

    // Architectural state
    logic [XLEN-1:0] r_regs [NREGS];

    // ID/EX pipeline register
    logic            r_valid;
    logic [XLEN-1:0] r_npc;
    logic [XLEN-1:0] r_a;
    logic [XLEN-1:0] r_b;
    logic [XLEN-1:0] r_imm;
    logic [4:0]      r_rd;
    logic [6:0]      r_opcode;
    logic [2:0]      r_funct3;
    logic            r_funct7b5;
    logic            r_is_load;
    logic            r_reg_write;

    // Instruction fields
    logic [6:0]      w_opcode;
    logic [4:0]      w_rs1;
    logic [4:0]      w_rs2;
    logic [4:0]      w_rd;
    logic [2:0]      w_funct3;
    logic            w_funct7b5;

    // Decode results
    logic            w_legal;
    logic            w_uses_rs1;
    logic            w_uses_rs2;
    logic            w_writes_rd;
    logic            w_is_load;
    logic [31:0]     w_imm32;
    logic [XLEN-1:0] w_rs1_val;
    logic [XLEN-1:0] w_rs2_val;
    logic            w_rs1_hit;
    logic            w_rs2_hit;
    logic            w_hazard;
    logic            w_bubble;

    assign w_opcode   = if_inst[6:0];
    assign w_rd       = if_inst[11:7];
    assign w_funct3   = if_inst[14:12];
    assign w_rs1      = if_inst[19:15];
    assign w_rs2      = if_inst[24:20];
    assign w_funct7b5 = if_inst[30];

    // Classify the opcode: legality, which sources matter, rd write, immediate.
    always_comb begin
        w_legal     = 1'b0;
        w_uses_rs1  = 1'b0;
        w_uses_rs2  = 1'b0;
        w_writes_rd = 1'b0;
        w_is_load   = 1'b0;
        w_imm32     = 32'd0;
        case (w_opcode)
            OP_LUI, OP_AUIPC: begin
                w_legal     = 1'b1;
                w_writes_rd = 1'b1;
                w_imm32     = imm_u(if_inst);
            end
            OP_JAL: begin
                w_legal     = 1'b1;
                w_writes_rd = 1'b1;
                w_imm32     = imm_j(if_inst);
            end
            OP_JALR, OP_OPIMM: begin
                w_legal     = 1'b1;
                w_uses_rs1  = 1'b1;
                w_writes_rd = 1'b1;
                w_imm32     = imm_i(if_inst);
            end
            OP_LOAD: begin
                w_legal     = 1'b1;
                w_uses_rs1  = 1'b1;
                w_writes_rd = 1'b1;
                w_is_load   = 1'b1;
                w_imm32     = imm_i(if_inst);
            end
            OP_BRANCH: begin
                w_legal     = 1'b1;
                w_uses_rs1  = 1'b1;
                w_uses_rs2  = 1'b1;
                w_imm32     = imm_b(if_inst);
            end
            OP_STORE: begin
                w_legal     = 1'b1;
                w_uses_rs1  = 1'b1;
                w_uses_rs2  = 1'b1;
                w_imm32     = imm_s(if_inst);
            end
            OP_OP: begin
                w_legal     = 1'b1;
                w_uses_rs1  = 1'b1;
                w_uses_rs2  = 1'b1;
                w_writes_rd = 1'b1;
            end
            default: begin
                w_legal     = 1'b0;
            end
        endcase
    end

    // Register file read for rs1; x0 reads zero, optional same-cycle forward.
    always_comb begin
        w_rs1_val = r_regs[w_rs1];
        if (w_rs1 == 5'd0) begin
            w_rs1_val = '0;
        end
`ifdef DECODE_STAGE_WB_BYPASS_EN
        else if (wb_en && (wb_rd != 5'd0) && (wb_rd == w_rs1)) begin
            w_rs1_val = wb_data;
        end
`endif
    end

    // Register file read for rs2; x0 reads zero, optional same-cycle forward.
    always_comb begin
        w_rs2_val = r_regs[w_rs2];
        if (w_rs2 == 5'd0) begin
            w_rs2_val = '0;
        end
`ifdef DECODE_STAGE_WB_BYPASS_EN
        else if (wb_en && (wb_rd != 5'd0) && (wb_rd == w_rs2)) begin
            w_rs2_val = wb_data;
        end
`endif
    end

    // Load-use: only sources the opcode actually consumes can trigger a stall,
    // and a taken branch squashes the stall because the instruction is flushed.
    assign w_rs1_hit = w_uses_rs1 && (w_rs1 == r_rd);
    assign w_rs2_hit = w_uses_rs2 && (w_rs2 == r_rd);
    assign w_hazard  = r_valid && r_is_load && r_reg_write
                       && (w_rs1_hit || w_rs2_hit) && !branch_cond;
    assign w_bubble  = branch_cond || w_hazard || !w_legal;

    assign hazard  = w_hazard;
    assign illegal = !w_legal;

    // Synchronous register file write; x0 is never written.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) begin
                r_regs[i] <= '0;
            end
        end else if (wb_en && (wb_rd != 5'd0)) begin
            r_regs[wb_rd] <= wb_data;
        end
    end

    // ID/EX register: reset, then flush/stall/illegal bubble, else issue.
    always_ff @(posedge clk) begin
        if (reset || w_bubble) begin
            r_valid     <= 1'b0;
            r_npc       <= '0;
            r_a         <= '0;
            r_b         <= '0;
            r_imm       <= '0;
            r_rd        <= 5'd0;
            r_opcode    <= 7'd0;
            r_funct3    <= 3'd0;
            r_funct7b5  <= 1'b0;
            r_is_load   <= 1'b0;
            r_reg_write <= 1'b0;
        end else begin
            r_valid     <= 1'b1;
            r_npc       <= if_npc;
            r_a         <= w_rs1_val;
            r_b         <= w_rs2_val;
            r_imm       <= sext_xlen(w_imm32);
            r_rd        <= w_rd;
            r_opcode    <= w_opcode;
            r_funct3    <= w_funct3;
            r_funct7b5  <= w_funct7b5;
            r_is_load   <= w_is_load;
            r_reg_write <= w_writes_rd && (w_rd != 5'd0);
        end
    end

    assign id_ex_valid     = r_valid;
    assign id_ex_npc       = r_npc;
    assign id_ex_a         = r_a;
    assign id_ex_b         = r_b;
    assign id_ex_imm       = r_imm;
    assign id_ex_rd        = r_rd;
    assign id_ex_opcode    = r_opcode;
    assign id_ex_funct3    = r_funct3;
    assign id_ex_funct7b5  = r_funct7b5;
    assign id_ex_is_load   = r_is_load;
    assign id_ex_reg_write = r_reg_write;

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: directed scenarios plus a randomized run,
// all compared against a behavioural model of the ID stage.
module tb_decode_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] if_inst;
    logic [31:0] if_npc;
    logic        branch_cond;
    logic        wb_en;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        hazard;
    logic        id_ex_valid;
    logic [31:0] id_ex_npc;
    logic [31:0] id_ex_a;
    logic [31:0] id_ex_b;
    logic [31:0] id_ex_imm;
    logic [4:0]  id_ex_rd;
    logic [6:0]  id_ex_opcode;
    logic [2:0]  id_ex_funct3;
    logic        id_ex_funct7b5;
    logic        id_ex_is_load;
    logic        id_ex_reg_write;
    logic        illegal;

    always #5 clk = ~clk;

    decode_stage dut (
        .clk            (clk),
        .reset          (reset),
        .if_inst        (if_inst),
        .if_npc         (if_npc),
        .branch_cond    (branch_cond),
        .wb_en          (wb_en),
        .wb_rd          (wb_rd),
        .wb_data        (wb_data),
        .hazard         (hazard),
        .id_ex_valid    (id_ex_valid),
        .id_ex_npc      (id_ex_npc),
        .id_ex_a        (id_ex_a),
        .id_ex_b        (id_ex_b),
        .id_ex_imm      (id_ex_imm),
        .id_ex_rd       (id_ex_rd),
        .id_ex_opcode   (id_ex_opcode),
        .id_ex_funct3   (id_ex_funct3),
        .id_ex_funct7b5 (id_ex_funct7b5),
        .id_ex_is_load  (id_ex_is_load),
        .id_ex_reg_write(id_ex_reg_write),
        .illegal        (illegal)
    );

    typedef struct packed {
        logic        valid;
        logic [31:0] npc;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] imm;
        logic [4:0]  rd;
        logic [6:0]  opcode;
        logic [2:0]  funct3;
        logic        funct7b5;
        logic        is_load;
        logic        reg_write;
    } idex_t;

    int          checks   = 0;
    int          failures = 0;
    logic [31:0] m_regs [32];
    idex_t       m_ex = '0;
    logic        exp_hazard, exp_illegal, obs_hazard, obs_illegal;

    // Architectural meaning of each opcode: legality, sources, rd write, immediate.
    function automatic void ref_decode(input logic [31:0] inst, output bit legal,
                                       output bit u1, output bit u2, output bit wr,
                                       output bit ld, output logic [31:0] imm);
        int s;
        s = int'(inst);
        legal = 1; u1 = 0; u2 = 0; wr = 0; ld = 0; imm = 0;
        case (inst[6:0])
            7'h37, 7'h17: begin wr = 1; imm = inst & 32'hFFFF_F000; end
            7'h6F: begin
                wr = 1;
                imm = (s >>> 31) * 1048576 + int'(inst[19:12]) * 4096
                      + int'(inst[20]) * 2048 + int'(inst[30:21]) * 2;
            end
            7'h67, 7'h13: begin u1 = 1; wr = 1; imm = s >>> 20; end
            7'h03: begin u1 = 1; wr = 1; ld = 1; imm = s >>> 20; end
            7'h63: begin
                u1 = 1; u2 = 1;
                imm = (s >>> 31) * 4096 + int'(inst[7]) * 2048
                      + int'(inst[30:25]) * 32 + int'(inst[11:8]) * 2;
            end
            7'h23: begin u1 = 1; u2 = 1; imm = (s >>> 25) * 32 + int'(inst[11:7]); end
            7'h33: begin u1 = 1; u2 = 1; wr = 1; end
            default: legal = 0;
        endcase
    endfunction

    // Snapshot of the DUT's ID/EX; funct fields only meaningful when valid.
    function automatic idex_t dut_ex();
        idex_t o;
        o.valid     = id_ex_valid;
        o.npc       = id_ex_npc;
        o.a         = id_ex_a;
        o.b         = id_ex_b;
        o.imm       = id_ex_imm;
        o.rd        = id_ex_rd;
        o.opcode    = id_ex_opcode;
        o.funct3    = id_ex_valid ? id_ex_funct3 : 3'd0;
        o.funct7b5  = id_ex_valid & id_ex_funct7b5;
        o.is_load   = id_ex_is_load;
        o.reg_write = id_ex_reg_write;
        return o;
    endfunction

    // Drive one cycle, sample combinational outputs before the edge, advance model.
    task automatic cycle(input logic [31:0] inst, input logic [31:0] npc, input logic bc,
                         input logic wen, input logic [4:0] wrd, input logic [31:0] wd,
                         input logic rst);
        bit          legal, u1, u2, wr, ld;
        logic [31:0] imm, va, vb;
        logic [4:0]  rs1, rs2, rd;
        idex_t       nx;
        if_inst = inst; if_npc = npc; branch_cond = bc;
        wb_en = wen; wb_rd = wrd; wb_data = wd; reset = rst;
        #2;
        obs_hazard  = hazard;
        obs_illegal = illegal;
        ref_decode(inst, legal, u1, u2, wr, ld, imm);
        rs1 = inst[19:15]; rs2 = inst[24:20]; rd = inst[11:7];
        exp_hazard = m_ex.valid && m_ex.is_load && m_ex.reg_write
                     && ((u1 && rs1 == m_ex.rd) || (u2 && rs2 == m_ex.rd)) && !bc;
        exp_illegal = !legal;
        va = (rs1 == 0) ? 32'd0 : m_regs[rs1];
        vb = (rs2 == 0) ? 32'd0 : m_regs[rs2];
`ifdef DECODE_STAGE_WB_BYPASS_EN
        if (wen && wrd != 0 && wrd == rs1) va = wd;
        if (wen && wrd != 0 && wrd == rs2) vb = wd;
`endif
        nx = '0;
        if (!rst && !bc && !exp_hazard && legal) begin
            nx.valid = 1; nx.npc = npc; nx.a = va; nx.b = vb; nx.imm = imm;
            nx.rd = rd; nx.opcode = inst[6:0]; nx.funct3 = inst[14:12];
            nx.funct7b5 = inst[30]; nx.is_load = ld; nx.reg_write = wr && (rd != 0);
        end
        @(posedge clk);
        m_ex = nx;
        if (rst) begin
            for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
        end else if (wen && wrd != 0) begin
            m_regs[wrd] = wd;
        end
        #1;
    endtask

    localparam logic [31:0] NOP      = 32'h0000_0013;
    localparam logic [31:0] LW_X5    = 32'h0000_A283;  // lw x5,0(x1)
    localparam logic [31:0] ADD_X6   = 32'h0002_8333;  // add x6,x5,x0

    task automatic test_reset();
        cycle(32'd0, 32'd0, 0, 0, 5'd0, 32'd0, 1);
        cycle(32'd0, 32'd0, 0, 0, 5'd0, 32'd0, 1);
        checks++;
        if (dut_ex() !== '0) begin failures++; $display("FAIL reset_idex got=%h exp=0", dut_ex()); end
        checks++;
        if (obs_hazard !== 1'b0) begin failures++; $display("FAIL reset_hazard got=%b exp=0", obs_hazard); end
    endtask

    task automatic test_addi();
        cycle(32'h0050_0093, 32'd4, 0, 0, 5'd0, 32'd0, 0);
        checks++;
        if (obs_hazard !== 1'b0) begin failures++; $display("FAIL addi_hazard got=%b exp=0", obs_hazard); end
        checks++;
        if ({id_ex_valid, id_ex_rd, id_ex_reg_write} !== {1'b1, 5'd1, 1'b1}) begin
            failures++;
            $display("FAIL addi_ctrl got=%b/%0d/%b exp=1/1/1", id_ex_valid, id_ex_rd, id_ex_reg_write);
        end
        checks++;
        if ({id_ex_imm, id_ex_a, id_ex_npc} !== {32'd5, 32'd0, 32'd4}) begin
            failures++;
            $display("FAIL addi_data got=imm %h a %h npc %h exp=5/0/4", id_ex_imm, id_ex_a, id_ex_npc);
        end
    endtask

    task automatic test_regfile();
        cycle(NOP, 32'd8, 0, 1, 5'd2, 32'h1234, 0);
        cycle(32'h0021_01B3, 32'd12, 0, 0, 5'd0, 32'd0, 0);
        checks++;
        if ({id_ex_a, id_ex_b, id_ex_imm} !== {32'h1234, 32'h1234, 32'd0}) begin
            failures++;
            $display("FAIL rf_add got=a %h b %h imm %h exp=1234/1234/0", id_ex_a, id_ex_b, id_ex_imm);
        end
        cycle(NOP, 32'd16, 0, 1, 5'd0, 32'hFFFF, 0);
        cycle(32'h0000_01B3, 32'd20, 0, 0, 5'd0, 32'd0, 0);
        checks++;
        if ({id_ex_a, id_ex_b, id_ex_rd} !== {32'd0, 32'd0, 5'd3}) begin
            failures++;
            $display("FAIL rf_x0 got=a %h b %h rd %0d exp=0/0/3", id_ex_a, id_ex_b, id_ex_rd);
        end
    endtask

    task automatic test_load_use();
        cycle(LW_X5, 32'd24, 0, 0, 5'd0, 32'd0, 0);
        cycle(ADD_X6, 32'd28, 0, 0, 5'd0, 32'd0, 0);
        checks++;
        if ({obs_hazard, id_ex_valid} !== 2'b10) begin
            failures++;
            $display("FAIL lu_stall got=hazard %b valid %b exp=1/0", obs_hazard, id_ex_valid);
        end
        cycle(ADD_X6, 32'd28, 0, 0, 5'd0, 32'd0, 0);
        checks++;
        if ({obs_hazard, id_ex_valid, id_ex_rd} !== {1'b0, 1'b1, 5'd6}) begin
            failures++;
            $display("FAIL lu_issue got=hazard %b valid %b rd %0d exp=0/1/6", obs_hazard, id_ex_valid, id_ex_rd);
        end
    endtask

    task automatic test_lui_no_hazard();
        cycle(LW_X5, 32'd32, 0, 0, 5'd0, 32'd0, 0);
        cycle(32'h1234_52B7, 32'd36, 0, 0, 5'd0, 32'd0, 0);
        checks++;
        if ({obs_hazard, id_ex_valid, id_ex_imm} !== {1'b0, 1'b1, 32'h1234_5000}) begin
            failures++;
            $display("FAIL lui got=hazard %b valid %b imm %h exp=0/1/12345000", obs_hazard, id_ex_valid, id_ex_imm);
        end
    endtask

    task automatic test_branch_flush();
        cycle(LW_X5, 32'd40, 0, 0, 5'd0, 32'd0, 0);
        cycle(ADD_X6, 32'd44, 1, 0, 5'd0, 32'd0, 0);
        checks++;
        if ({obs_hazard, id_ex_valid, id_ex_reg_write} !== 3'b000) begin
            failures++;
            $display("FAIL flush got=hazard %b valid %b rw %b exp=0/0/0", obs_hazard, id_ex_valid, id_ex_reg_write);
        end
    endtask

    task automatic test_beq_illegal();
        cycle(32'hFE00_0CE3, 32'd48, 0, 0, 5'd0, 32'd0, 0);
        checks++;
        if ({id_ex_valid, id_ex_reg_write, id_ex_imm} !== {1'b1, 1'b0, 32'hFFFF_FFF8}) begin
            failures++;
            $display("FAIL beq got=valid %b rw %b imm %h exp=1/0/fffffff8", id_ex_valid, id_ex_reg_write, id_ex_imm);
        end
        cycle(32'h0000_007F, 32'd52, 0, 0, 5'd0, 32'd0, 0);
        checks++;
        if ({obs_illegal, id_ex_valid} !== 2'b10) begin
            failures++;
            $display("FAIL illegal got=illegal %b valid %b exp=1/0", obs_illegal, id_ex_valid);
        end
    endtask

    task automatic test_wb_same_cycle();
        logic [31:0] want;
`ifdef DECODE_STAGE_WB_BYPASS_EN
        want = 32'd7;
`else
        want = 32'd3;
`endif
        cycle(NOP, 32'd56, 0, 1, 5'd4, 32'd3, 0);
        cycle(32'h0002_0413, 32'd60, 0, 1, 5'd4, 32'd7, 0);
        checks++;
        if (id_ex_a !== want) begin failures++; $display("FAIL wb_same got=%h exp=%h", id_ex_a, want); end
        cycle(32'h0002_0413, 32'd64, 0, 0, 5'd0, 32'd0, 0);
        checks++;
        if (id_ex_a !== 32'd7) begin failures++; $display("FAIL wb_after got=%h exp=7", id_ex_a); end
    endtask

    task automatic test_reset_mid_stall();
        cycle(LW_X5, 32'd68, 0, 0, 5'd0, 32'd0, 0);
        cycle(ADD_X6, 32'd72, 0, 0, 5'd0, 32'd0, 1);
        checks++;
        if ({obs_hazard, id_ex_valid} !== 2'b10) begin
            failures++;
            $display("FAIL rst_stall got=hazard %b valid %b exp=1/0", obs_hazard, id_ex_valid);
        end
        cycle(ADD_X6, 32'd72, 0, 0, 5'd0, 32'd0, 0);
        checks++;
        if ({obs_hazard, id_ex_valid, id_ex_rd} !== {1'b0, 1'b1, 5'd6}) begin
            failures++;
            $display("FAIL rst_resume got=hazard %b valid %b rd %0d exp=0/1/6", obs_hazard, id_ex_valid, id_ex_rd);
        end
    endtask

    task automatic test_random();
        logic [31:0] inst;
        logic [6:0]  op;
        for (int n = 0; n < 600; n++) begin
            case ($urandom_range(0, 9))
                0: op = 7'h37; 1: op = 7'h17; 2: op = 7'h6F; 3: op = 7'h67;
                4: op = 7'h63; 5: op = 7'h03; 6: op = 7'h23; 7: op = 7'h13;
                8: op = 7'h33; default: op = 7'($urandom);
            endcase
            if ($urandom_range(0, 2) == 0) op = 7'h03;
            inst = $urandom;
            inst[6:0]   = op;
            inst[11:7]  = 5'($urandom_range(0, 7));
            inst[19:15] = 5'($urandom_range(0, 7));
            inst[24:20] = 5'($urandom_range(0, 7));
            cycle(inst, $urandom, ($urandom_range(0, 9) == 0), 1'($urandom),
                  5'($urandom_range(0, 7)), $urandom, ($urandom_range(0, 49) == 0));
            checks++;
            if (obs_hazard !== exp_hazard) begin
                failures++; $display("FAIL rnd_hazard n=%0d got=%b exp=%b", n, obs_hazard, exp_hazard);
            end
            checks++;
            if (obs_illegal !== exp_illegal) begin
                failures++; $display("FAIL rnd_illegal n=%0d got=%b exp=%b", n, obs_illegal, exp_illegal);
            end
            checks++;
            if (dut_ex() !== m_ex) begin
                failures++; $display("FAIL rnd_idex n=%0d got=%h exp=%h", n, dut_ex(), m_ex);
            end
        end
    endtask

    initial begin
        test_reset();
        test_addi();
        test_regfile();
        test_load_use();
        test_lui_no_hazard();
        test_branch_flush();
        test_beq_illegal();
        test_wb_same_cycle();
        test_reset_mid_stall();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
